// File: rtl/branch_predict_redirect.sv
// Branch predictor and redirect unit: 2-bit BHT prediction at fetch, EX resolution, registered redirect/flush.
// Ports: if_* / pred_* fetch side, ex_* resolve side, redirect_valid/redirect_pc/flush out; optional BHT_STATS_EN adds stat_* counters.
module branch_predict_redirect #(
    parameter int          BHT_IDX_W = 6,
    parameter logic [1:0]  BHT_INIT  = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic [31:0] pred_next_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_pred_next_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
`ifdef BHT_STATS_EN
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        flush
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic                 if_is_br;
    logic [31:0]          br_imm;
    logic                 res;
    logic                 mispredict;
    logic [31:0]          actual_next;
    logic [1:0]           ctr;
    logic [1:0]           ctr_nxt;
    logic                 unused_bits;

    assign unused_bits = ^if_instr[24:12];

    assign if_idx   = if_pc[BHT_IDX_W+1:2];
    assign ex_idx   = ex_pc[BHT_IDX_W+1:2];
    assign if_is_br = (if_instr[6:0] == 7'b1100011);
    assign br_imm   = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                       if_instr[30:25], if_instr[11:8], 1'b0};

    always_comb begin
        pred_taken   = 1'b0;
        pred_next_pc = if_pc + 32'd4;
        if (if_is_br) begin
            pred_taken = bht[if_idx][1];
            if (bht[if_idx][1])
                pred_next_pc = if_pc + br_imm;
        end
    end

    // Squash anything arriving in EX while the flush pulse is high.
    assign res         = ex_valid & ex_is_branch & ~flush;
    assign actual_next = ex_taken ? ex_target : ex_pc + 32'd4;
    assign mispredict  = res & (actual_next != ex_pred_next_pc);

    always_comb begin
        ctr     = bht[ex_idx];
        ctr_nxt = ctr;
        unique case (1'b1)
            ex_taken && (ctr != 2'b11):  ctr_nxt = ctr + 2'd1;
            !ex_taken && (ctr != 2'b00): ctr_nxt = ctr - 2'd1;
            default:                     ctr_nxt = ctr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++)
                bht[i] <= BHT_INIT;
        end else if (res) begin
            bht[ex_idx] <= ctr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            redirect_valid <= mispredict;
            flush          <= mispredict;
            if (mispredict)
                redirect_pc <= actual_next;
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (res && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_redirect.sv
// Directed-vector bench for branch_predict_redirect.
// Checks prediction, BHT saturation, redirect pulse, flush squash, aliasing, wrap and async reset.
module tb_branch_predict_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BHT_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_br = 0;
    int exp_mp = 0;

    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
    localparam logic [31:0] ADDI    = 32'h0000_0013;

    always #5 clk = ~clk;

    branch_predict_redirect dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .pred_next_pc    (pred_next_pc),
        .pred_taken      (pred_taken),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_pc           (ex_pc),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ex_pred_next_pc (ex_pred_next_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
`ifdef BHT_STATS_EN
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .flush           (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pred(input string tag, input logic [31:0] pc,
                        input logic [31:0] instr, input logic tk,
                        input logic [31:0] nxt);
        if_pc    = pc;
        if_instr = instr;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, "_next"}, pred_next_pc, nxt);
    endtask

    // One resolution then one idle cycle so the next is never squashed.
    task automatic resolve(input string tag, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt,
                           input logic [31:0] pnext, input logic redir,
                           input logic [31:0] rpc);
        ex_valid        = 1'b1;
        ex_is_branch    = 1'b1;
        ex_pc           = pc;
        ex_taken        = tk;
        ex_target       = tgt;
        ex_pred_next_pc = pnext;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        exp_br++;
        if (redir) exp_mp++;
        chk({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, redir});
        chk({tag, "_fl"}, {31'd0, flush}, {31'd0, redir});
        if (redir)
            chk({tag, "_rpc"}, redirect_pc, rpc);
        @(posedge clk);
        #1;
        chk({tag, "_rv_end"}, {31'd0, redirect_valid}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        if_pc           = 32'd0;
        if_instr        = 32'd0;
        ex_valid        = 1'b0;
        ex_is_branch    = 1'b0;
        ex_pc           = 32'd0;
        ex_taken        = 1'b0;
        ex_target       = 32'd0;
        ex_pred_next_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("rst_fl", {31'd0, flush}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        rst = 1'b0;

        pred("beq_init", 32'h100, BEQ_P16, 1'b0, 32'h104);
        pred("addi", 32'h200, ADDI, 1'b0, 32'h204);

        // Mispredict at 0x100, then a resolution that must be squashed.
        ex_valid        = 1'b1;
        ex_is_branch    = 1'b1;
        ex_pc           = 32'h100;
        ex_taken        = 1'b1;
        ex_target       = 32'h110;
        ex_pred_next_pc = 32'h104;
        @(posedge clk);
        #1;
        exp_br++;
        exp_mp++;
        chk("mp_rv", {31'd0, redirect_valid}, 32'd1);
        chk("mp_fl", {31'd0, flush}, 32'd1);
        chk("mp_rpc", redirect_pc, 32'h110);
        ex_taken        = 1'b0;
        ex_pred_next_pc = 32'h110;
        pred("after_mp", 32'h100, BEQ_P16, 1'b1, 32'h110);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        chk("sq_rv", {31'd0, redirect_valid}, 32'd0);
        chk("sq_fl", {31'd0, flush}, 32'd0);
        chk("sq_rpc_hold", redirect_pc, 32'h110);
        pred("sq_noupd", 32'h100, BEQ_P16, 1'b1, 32'h110);

        // Saturate up to 11, step down once: still taken.
        for (int i = 0; i < 3; i++)
            resolve("tk_ok", 32'h100, 1'b1, 32'h110, 32'h110, 1'b0, 32'h0);
        pred("sat11", 32'h100, BEQ_P16, 1'b1, 32'h110);
        resolve("nt_mp", 32'h100, 1'b0, 32'h110, 32'h110, 1'b1, 32'h104);
        pred("ctr10", 32'h100, BEQ_P16, 1'b1, 32'h110);

        // Four not-taken: 10->01->00->00->00.
        for (int i = 0; i < 4; i++)
            resolve("nt_ok", 32'h100, 1'b0, 32'h110, 32'h104, 1'b0, 32'h0);
        pred("ctr00", 32'h100, BEQ_P16, 1'b0, 32'h104);
        resolve("tk_a", 32'h100, 1'b1, 32'h110, 32'h104, 1'b1, 32'h110);
        pred("ctr01", 32'h100, BEQ_P16, 1'b0, 32'h104);
        resolve("tk_b", 32'h100, 1'b1, 32'h110, 32'h104, 1'b1, 32'h110);
        pred("ctr10b", 32'h100, BEQ_P16, 1'b1, 32'h110);

        pred("alias", 32'h200, BEQ_P16, 1'b1, 32'h210);

        pred("neg_nt", 32'h4, BEQ_M8, 1'b0, 32'h8);
        resolve("neg_tk", 32'h4, 1'b1, 32'hFFFF_FFFC, 32'h8, 1'b1,
                32'hFFFF_FFFC);
        pred("neg_wrap", 32'h4, BEQ_M8, 1'b1, 32'hFFFF_FFFC);

`ifdef BHT_STATS_EN
        chk("st_br", stat_branches, exp_br);
        chk("st_mp", stat_mispredicts, exp_mp);
`endif

        // Mispredict, then async reset mid-cycle before the next edge.
        ex_valid        = 1'b1;
        ex_is_branch    = 1'b1;
        ex_pc           = 32'h100;
        ex_taken        = 1'b0;
        ex_target       = 32'h110;
        ex_pred_next_pc = 32'h110;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        chk("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("arst_fl", {31'd0, flush}, 32'd0);
        chk("arst_rpc", redirect_pc, 32'd0);
        pred("arst_i0", 32'h100, BEQ_P16, 1'b0, 32'h104);
        pred("arst_i1", 32'h4, BEQ_M8, 1'b0, 32'h8);
        exp_br = 0;
        exp_mp = 0;
`ifdef BHT_STATS_EN
        chk("arst_st_br", stat_branches, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        // One taken step from BHT_INIT must flip to taken.
        resolve("post_rst", 32'h100, 1'b1, 32'h110, 32'h104, 1'b1, 32'h110);
        pred("post_rst_p", 32'h100, BEQ_P16, 1'b1, 32'h110);
`ifdef BHT_STATS_EN
        chk("st_br_end", stat_branches, exp_br);
        chk("st_mp_end", stat_mispredicts, exp_mp);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_redirect.md
Name: branch_predict_redirect

Overview:
- Front-end partner of the EX-stage branch comparator: predicts conditional-branch direction at fetch and consumes the EX branch outcome.
- Holds a 2-bit saturating-counter branch history table (BHT). Supplies the predicted next PC to IF.
- On misprediction, issues a registered PC redirect plus an IF/ID flush pulse.

Parameters:
- BHT_IDX_W, 6, index width; table holds 2**BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].
- BHT_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- if_pc  input  32  PC of instruction in fetch
- if_instr  input  32  fetched instruction word
- pred_next_pc  output  32  predicted next fetch PC (combinational)
- pred_taken  output  1  prediction direction (combinational)
- ex_valid  input  1  EX stage holds a valid instruction
- ex_is_branch  input  1  EX instruction is a conditional branch (opcode 7'b1100011)
- ex_pc  input  32  PC of EX instruction
- ex_taken  input  1  resolved branch outcome from the comparator
- ex_target  input  32  resolved taken target
- ex_pred_next_pc  input  32  pred_next_pc carried down the pipe with this instruction
- redirect_valid  output  1  registered one-cycle redirect request
- redirect_pc  output  32  registered correct next PC
- flush  output  1  registered; kill IF/ID and squash EX inputs this cycle

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On rst, all counters go to BHT_INIT, and redirect_valid, flush and redirect_pc go to 0 immediately, with no clock edge needed. A pending redirect is discarded.
- Prediction (combinational):
  - Condition: if_instr[6:0]==7'b1100011.
  - When true: imm = sign-extended B-immediate {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; pred_taken = BHT[idx(if_pc)][1]; pred_next_pc = pred_taken ? if_pc+imm : if_pc+4.
  - Otherwise: pred_taken=0 and pred_next_pc=if_pc+4.
  - All adds are 32-bit modulo with wrap; no overflow flag.
- Resolution: res = ex_valid & ex_is_branch & ~flush.
  - actual_next = ex_taken ? ex_target : ex_pc+4.
  - mispredict = res & (actual_next != ex_pred_next_pc).
- BHT update at posedge when res=1:
  - taken: counter+1, saturating at 2'b11.
  - not taken: counter-1, saturating at 2'b00.
  - Entries are not touched when res=0.
- Read/write same index in same cycle: prediction uses the pre-update value. There is no bypass.
- Redirect at posedge:
  - redirect_valid <= mispredict; flush <= mispredict; redirect_pc <= actual_next when mispredict, else holds.
  - Latency is one cycle after resolution; the pulse width is exactly one cycle.
- Back-to-back: while flush=1 the EX inputs are squashed. There is no update and no redirect, so two consecutive redirects cannot occur.
- Aliasing: no tags. PCs with equal index bits share a counter.

Optional Feature:
- Macro: BHT_STATS_EN.
- With macro defined:
  - Adds output ports stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each res; stat_mispredicts increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on rst.
- Without macro: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x100, if_instr=BEQ with offset +16 (0x00000863) -> pred_taken=0, pred_next_pc=0x104. Non-branch ADDI at 0x200 -> pred_next_pc=0x204.
- Resolve ex_pc=0x100, ex_taken=1, ex_target=0x110, ex_pred_next_pc=0x104 -> next cycle redirect_valid=1, flush=1, redirect_pc=0x110 for exactly one cycle; BHT[0] goes 01->10; fetch at 0x100 now gives pred_next_pc=0x110.
- Three taken resolutions at 0x100 then one not-taken -> counter 11 then 10, so still predicts taken. Four more not-taken -> counter 00, holds 00, no underflow.
- Correctly predicted resolution (ex_pred_next_pc==actual_next) -> redirect_valid stays 0; counter still updates. A resolution presented in the cycle flush=1 -> no redirect, no BHT change (stat_branches unchanged with BHT_STATS_EN).
- Assert rst asynchronously mid-cycle after a mispredict, before the edge -> redirect_valid and flush read 0 immediately; all counters read BHT_INIT.
- Aliasing: train 0x100 to taken, then fetch a branch at 0x200 (same index 0) -> predicts taken. Negative offset -8 at 0x0000_0004 -> pred_next_pc=0xFFFF_FFFC when taken (wrap).
